// File: rtl/softmax_pkg.sv
// Shared types and constants for the softmax normalisation stage.
// Fixed-point formats: exponent Q4.12, sum Q8.8, probability Q1.15.
package softmax_pkg;

    localparam int DATA_W     = 16;
    localparam int NUM_DATA   = 10;

    localparam int EXP_FRAC   = 12;
    localparam int SUM_FRAC   = 8;
    localparam int OUT_FRAC   = 15;

    // Q4.12 / Q8.8 -> Q1.15 needs the dividend pre-shifted by 11
    localparam int DIV_SHIFT  = OUT_FRAC - EXP_FRAC + SUM_FRAC;
    localparam int DIVIDEND_W = DATA_W + DIV_SHIFT;
    localparam int QUO_W      = DATA_W;
    localparam int REM_W      = DATA_W + 1;

    localparam logic [DATA_W-1:0] SAT_VALUE = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_PREP,
        ST_ITER,
        ST_OUT,
        ST_DONE
    } state_e;

    // Quotient fits in QUO_W bits only while e < s * 2^(QUO_W - DIV_SHIFT)
    function automatic logic quotient_overflows(
        input logic [DATA_W-1:0] e,
        input logic [DATA_W-1:0] s
    );
        return (e >> (DATA_W - DIV_SHIFT)) >= s;
    endfunction

endpackage

// File: rtl/div_unit_16.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first.
// Caller guarantees dividend[26:16] < divisor so the quotient fits 16 bits.
module div_unit_16
    import softmax_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [DIVIDEND_W-1:0] dividend_i,
    input  logic [DATA_W-1:0]     divisor_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [QUO_W-1:0]      quotient_o
);

    localparam int          CNT_W = $clog2(QUO_W);
    localparam int          PAD_W = REM_W - (DIVIDEND_W - QUO_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(QUO_W - 1);

    logic [REM_W-1:0]  rem_q, rem_d;
    logic [QUO_W-1:0]  low_q, low_d;
    logic [QUO_W-1:0]  quo_q, quo_d;
    logic [DATA_W-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;

    logic [REM_W-1:0]  trial;
    logic [REM_W-1:0]  diff;
    logic              take;

    always_comb begin
        trial = {rem_q[REM_W-2:0], low_q[QUO_W-1]};
        diff  = trial - {1'b0, dvs_q};
        take  = rem_q[REM_W-1] | (trial >= {1'b0, dvs_q});

        rem_d  = rem_q;
        low_d  = low_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;

        if (start_i) begin
            rem_d  = {{PAD_W{1'b0}}, dividend_i[DIVIDEND_W-1:QUO_W]};
            low_d  = dividend_i[QUO_W-1:0];
            dvs_d  = divisor_i;
            quo_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d = take ? diff : trial;
            low_d = {low_q[QUO_W-2:0], 1'b0};
            quo_d = {quo_q[QUO_W-2:0], take};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rem_q  <= '0;
            low_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            low_q  <= low_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    // Final quotient is presented during the last iteration so the
    // caller can register it on the same edge the divider finishes.
    assign busy_o     = busy_q;
    assign done_o     = busy_q && (cnt_q == LAST);
    assign quotient_o = {quo_q[QUO_W-2:0], take};

endmodule

// File: rtl/divider_block_16.sv
// Softmax normalisation: buffers exponents, waits for the sum, then
// streams exp/sum quotients in arrival order as Q1.15 probabilities.
module divider_block_16
    import softmax_pkg::*;
#(
    parameter int data_size      = DATA_W,
    parameter int number_of_data = NUM_DATA
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [data_size-1:0] exp_data_i,
    input  logic                 exp_data_valid_i,
    input  logic [data_size-1:0] sum_data_i,
    input  logic                 sum_data_valid_i,
    input  logic                 softmax_ready_i,
    output logic [data_size-1:0] softmax_data_o,
    output logic                 softmax_data_valid_o,
    output logic                 softmax_done_o
);

    localparam int CNT_W = $clog2(number_of_data + 1);
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(number_of_data);

    state_e state_q, state_d;

    logic [data_size-1:0] buf_q [number_of_data];

    logic [CNT_W-1:0]     wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]     rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]     rd_cnt_inc;
    logic [data_size-1:0] sum_q, sum_d;
    logic [data_size-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;

    logic                 buf_we;
    logic [data_size-1:0] rd_word;
    logic                 sat;
    logic                 accept;

    logic                 div_start;
    logic                 div_busy;
    logic                 div_done;
    logic [QUO_W-1:0]     div_quo;

    assign rd_word    = buf_q[rd_cnt_q];
    assign sat        = quotient_overflows(rd_word, sum_q);
    assign rd_cnt_inc = rd_cnt_q + CNT_W'(1);
    assign accept     = (state_q == ST_OUT) && softmax_ready_i;
    assign buf_we     = (state_q == ST_LOAD) && exp_data_valid_i
                        && (wr_cnt_q != DEPTH);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_LOAD;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            sum_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            sum_q    <= sum_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    // Buffer contents are don't-care after reset, so no reset here.
    always_ff @(posedge clock_i) begin
        if (buf_we) begin
            buf_q[wr_cnt_q] <= exp_data_i;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_LOAD: begin
                if (sum_data_valid_i) begin
                    state_d = (wr_cnt_d == '0) ? ST_DONE : ST_PREP;
                end
            end
            ST_PREP: begin
                state_d = sat ? ST_OUT : ST_ITER;
            end
            ST_ITER: begin
                if (div_busy && div_done) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (softmax_ready_i) begin
                    state_d = (rd_cnt_inc == wr_cnt_q) ? ST_DONE : ST_PREP;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        sum_d     = sum_q;
        data_d    = data_q;
        div_start = 1'b0;

        if (buf_we) begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end
        if ((state_q == ST_LOAD) && sum_data_valid_i) begin
            sum_d = sum_data_i;
        end
        if (state_q == ST_PREP) begin
            if (sat) begin
                data_d = SAT_VALUE;
            end else begin
                div_start = 1'b1;
            end
        end
        if ((state_q == ST_ITER) && div_busy && div_done) begin
            data_d = div_quo;
        end
        if (accept) begin
            rd_cnt_d = rd_cnt_inc;
        end

        valid_d = (state_d == ST_OUT);
        done_d  = (state_d == ST_DONE);
    end

    div_unit_16 u_div (
        .clk_i      (clock_i),
        .rst_i      (reset_i),
        .start_i    (div_start),
        .dividend_i ({rd_word, {DIV_SHIFT{1'b0}}}),
        .divisor_i  (sum_q),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (div_quo)
    );

    assign softmax_data_o       = data_q;
    assign softmax_data_valid_o = valid_q;
    assign softmax_done_o       = done_q;

endmodule

// File: tb/tb_divider_block_16.sv
// Scoreboard bench for divider_block_16: directed vectors, expected
// quotients pushed at issue time and popped by an accept monitor.
module tb_divider_block_16;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b1;
    logic [15:0] exp_data_i = '0;
    logic        exp_data_valid_i = 1'b0;
    logic [15:0] sum_data_i = '0;
    logic        sum_data_valid_i = 1'b0;
    logic        softmax_ready_i = 1'b1;
    logic [15:0] softmax_data_o;
    logic        softmax_data_valid_o;
    logic        softmax_done_o;

    logic [15:0] exp_q [$];
    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clock_i = ~clock_i;

    divider_block_16 dut (
        .clock_i              (clock_i),
        .reset_i              (reset_i),
        .exp_data_i           (exp_data_i),
        .exp_data_valid_i     (exp_data_valid_i),
        .sum_data_i           (sum_data_i),
        .sum_data_valid_i     (sum_data_valid_i),
        .softmax_ready_i      (softmax_ready_i),
        .softmax_data_o       (softmax_data_o),
        .softmax_data_valid_o (softmax_data_valid_o),
        .softmax_done_o       (softmax_done_o)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every accepted result is compared against the oldest expectation
    always @(negedge clock_i) begin
        if (!reset_i && softmax_data_valid_o && softmax_ready_i) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_result: got 0x%0h expected none",
                         softmax_data_o);
            end else begin
                check("result", {16'h0, softmax_data_o}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset_i          = 1'b1;
        exp_data_valid_i = 1'b0;
        sum_data_valid_i = 1'b0;
        softmax_ready_i  = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clock_i);
        #1 reset_i = 1'b0;
    endtask

    task automatic write_exp(input logic [15:0] v);
        @(posedge clock_i);
        #1 exp_data_i = v;
        exp_data_valid_i = 1'b1;
        @(posedge clock_i);
        #1 exp_data_valid_i = 1'b0;
    endtask

    // Returns right at the edge that samples the sum
    task automatic give_sum(input logic [15:0] s);
        @(posedge clock_i);
        #1 sum_data_i = s;
        sum_data_valid_i = 1'b1;
        @(posedge clock_i);
    endtask

    // Edges from sum/accept edge until valid is seen
    task automatic meas_lat(output int n);
        n = 0;
        @(negedge clock_i);
        while (!softmax_data_valid_o && n < 60) begin
            @(negedge clock_i);
            n++;
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        @(negedge clock_i);
        while (!softmax_done_o && n < budget) begin
            @(negedge clock_i);
            n++;
        end
        check({name, "_done"}, {31'h0, softmax_done_o}, 32'd1);
        check({name, "_valid_low"}, {31'h0, softmax_data_valid_o}, 32'd0);
    endtask

    initial begin
        int lat;

        // Reset state
        do_reset();
        @(negedge clock_i);
        check("rst_data", {16'h0, softmax_data_o}, 32'h0);
        check("rst_valid", {31'h0, softmax_data_valid_o}, 32'd0);
        check("rst_done", {31'h0, softmax_done_o}, 32'd0);

        // Single element: 0x1000 / 0x0100 -> 0x8000
        write_exp(16'h1000);
        exp_q.push_back(16'h8000);
        give_sum(16'h0100);
        meas_lat(lat);
        check("single_latency", lat, 32'd17);
        wait_done("single", 50);
        check("single_drained", exp_q.size(), 32'd0);

        // Two elements, done sticky
        do_reset();
        write_exp(16'h1000);
        write_exp(16'h1000);
        exp_q.push_back(16'h4000);
        exp_q.push_back(16'h4000);
        give_sum(16'h0200);
        wait_done("two", 100);
        repeat (5) @(negedge clock_i);
        check("two_done_sticky", {31'h0, softmax_done_o}, 32'd1);
        check("two_drained", exp_q.size(), 32'd0);

        // Saturation with zero sum
        do_reset();
        write_exp(16'h1000);
        exp_q.push_back(16'hFFFF);
        give_sum(16'h0000);
        meas_lat(lat);
        check("sat0_latency", lat, 32'd1);
        wait_done("sat0", 20);

        // Saturation on E[15:5] >= sum, write and sum in the same cycle
        do_reset();
        @(posedge clock_i);
        #1 exp_data_i = 16'h2000;
        exp_data_valid_i = 1'b1;
        sum_data_i = 16'h0040;
        sum_data_valid_i = 1'b1;
        exp_q.push_back(16'hFFFF);
        @(posedge clock_i);
        #1 exp_data_valid_i = 1'b0;
        meas_lat(lat);
        check("sat1_latency", lat, 32'd1);
        wait_done("sat1", 20);

        // Empty vector: done the cycle after the sum is latched
        do_reset();
        give_sum(16'h0100);
        @(negedge clock_i);
        check("empty_done", {31'h0, softmax_done_o}, 32'd1);
        check("empty_valid", {31'h0, softmax_data_valid_o}, 32'd0);

        // Overflow: 12 writes, only 1..10 kept; a write during ITER is dropped
        do_reset();
        for (int v = 1; v <= 12; v++) begin
            write_exp(16'(v));
            if (v <= 10) exp_q.push_back(16'(v * 8));
        end
        give_sum(16'h0100);
        repeat (3) @(posedge clock_i);
        #1 exp_data_i = 16'h7777;
        exp_data_valid_i = 1'b1;
        @(posedge clock_i);
        #1 exp_data_valid_i = 1'b0;
        wait_done("ovf", 400);
        check("ovf_drained", exp_q.size(), 32'd0);

        // Backpressure: hold ready low for 5 cycles while valid
        do_reset();
        write_exp(16'h0800);
        write_exp(16'h0C00);
        exp_q.push_back(16'h4000);
        exp_q.push_back(16'h6000);
        #1 softmax_ready_i = 1'b0;
        give_sum(16'h0100);
        meas_lat(lat);
        check("bp_latency", lat, 32'd17);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid_hold", {31'h0, softmax_data_valid_o}, 32'd1);
            check("bp_data_hold", {16'h0, softmax_data_o}, 32'h4000);
            @(negedge clock_i);
        end
        @(posedge clock_i);
        #1 softmax_ready_i = 1'b1;
        wait_done("bp", 60);
        check("bp_drained", exp_q.size(), 32'd0);

        // Reset in the middle of element 2's division
        do_reset();
        write_exp(16'h1000);
        write_exp(16'h1000);
        exp_q.push_back(16'h8000);
        give_sum(16'h0100);
        meas_lat(lat);
        check("mid_first_latency", lat, 32'd17);
        repeat (3) @(posedge clock_i);
        #3 check("mid_iter_valid", {31'h0, softmax_data_valid_o}, 32'd0);
        reset_i = 1'b1;
        #1;
        check("mid_rst_data", {16'h0, softmax_data_o}, 32'h0);
        check("mid_rst_valid", {31'h0, softmax_data_valid_o}, 32'd0);
        check("mid_rst_done", {31'h0, softmax_done_o}, 32'd0);
        check("mid_first_drained", exp_q.size(), 32'd0);
        do_reset();
        write_exp(16'h0800);
        exp_q.push_back(16'h4000);
        give_sum(16'h0100);
        wait_done("fresh", 50);
        check("fresh_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
